// File: rtl/stream_fifo_if.sv
// Valid/ready stream bundle shared by both sides of the FIFO.
// The master drives valid and data, and the slave drives ready.
interface stream_fifo_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with registered head word,
// occupancy count, almost flags, synchronous flush and peak monitor.
module stream_fifo #(
  parameter  int DEPTH     = 16,
  parameter  int WIDTH     = 8,
  parameter  int AF_THRESH = DEPTH - 2,
  parameter  int AE_THRESH = 2,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  stream_fifo_if.slave     in_if,
  stream_fifo_if.master    out_if,
  output logic [CNT_W-1:0] count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] peak
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d, rd_nx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] peak_q, peak_d;
  logic [CNT_W-1:0] left;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] od_q, od_d;
  logic             push, pop;

  assign in_if.ready = rst_n & (cnt_q != FULL) & ~flush;
  assign push = in_if.valid & in_if.ready;
  assign pop  = ov_q & out_if.ready & ~flush;

  assign rd_nx = (rd_q == LAST) ? '0 : rd_q + PTR_W'(1);
  assign left  = cnt_q - CNT_W'(pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    od_d = od_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = (wr_q == LAST) ? '0 : wr_q + PTR_W'(1);
      if (pop) rd_d = rd_nx;
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      // Head comes from storage if words remain, else bypasses in_data.
      if (pop && left != '0) od_d = mem_q[rd_nx];
      else if (push && left == '0) od_d = in_if.data;
    end
    ov_d = (cnt_d != '0);
    peak_d = flush ? '0 : ((cnt_d > peak_q) ? cnt_d : peak_q);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_if.data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      peak_q <= '0;
      ov_q <= 1'b0;
      od_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      peak_q <= peak_d;
      ov_q <= ov_d;
      od_q <= od_d;
    end
  end

  assign out_if.valid = ov_q;
  assign out_if.data  = od_q;
  assign count        = cnt_q;
  assign peak         = peak_q;
  assign almost_full  = (cnt_q >= CNT_W'(AF_THRESH));
  assign almost_empty = (cnt_q <= CNT_W'(AE_THRESH));

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo at DEPTH=16 and DEPTH=5.
// A queue model per instance predicts every output each cycle.
module tb_stream_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, fl_a, fl_b;
  logic [4:0] cnt_a, pk_a;
  logic [2:0] cnt_b, pk_b;
  logic af_a, ae_a, af_b, ae_b;

  stream_fifo_if #(.WIDTH(8)) a_in ();
  stream_fifo_if #(.WIDTH(8)) a_out ();
  stream_fifo_if #(.WIDTH(8)) b_in ();
  stream_fifo_if #(.WIDTH(8)) b_out ();

  stream_fifo #(.DEPTH(16), .WIDTH(8)) u_a (
    .clk(clk), .rst_n(rst_a), .flush(fl_a),
    .in_if(a_in), .out_if(a_out),
    .count(cnt_a), .almost_full(af_a),
    .almost_empty(ae_a), .peak(pk_a)
  );

  stream_fifo #(.DEPTH(5), .WIDTH(8)) u_b (
    .clk(clk), .rst_n(rst_b), .flush(fl_b),
    .in_if(b_in), .out_if(b_out),
    .count(cnt_b), .almost_full(af_b),
    .almost_empty(ae_b), .peak(pk_b)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] mq [2][$];
  int mpk [2];

  task automatic chk(string nm, int k, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0d exp=%0d", nm, k, act, exp);
    end
  endtask

  task automatic mon(
    input int k, input int depth, input int af, input int ae,
    input logic rst, input logic ov, input logic ordy,
    input logic [7:0] od, input logic iv, input logic ir,
    input logic [7:0] id, input logic fl,
    input int cnt, input int pk, input logic afl, input logic ael
  );
    int sz;
    logic [7:0] e;
    if (!rst) begin
      mq[k].delete();
      mpk[k] = 0;
      chk("rst_count", k, cnt, 0);
      chk("rst_out_valid", k, int'(ov), 0);
      chk("rst_in_ready", k, int'(ir), 0);
      chk("rst_peak", k, pk, 0);
      chk("rst_af", k, int'(afl), 0);
      chk("rst_ae", k, int'(ael), 1);
      return;
    end
    sz = mq[k].size();
    chk("count", k, cnt, sz);
    chk("out_valid", k, int'(ov), int'(sz != 0));
    chk("in_ready", k, int'(ir), int'(sz < depth && !fl));
    chk("almost_full", k, int'(afl), int'(sz >= af));
    chk("almost_empty", k, int'(ael), int'(sz <= ae));
    chk("peak", k, pk, mpk[k]);
    if (fl) begin
      mq[k].delete();
      mpk[k] = 0;
      return;
    end
    if (sz != 0 && ordy) begin
      e = mq[k].pop_front();
      chk("out_data", k, int'(od), int'(e));
    end
    if (iv && sz < depth) mq[k].push_back(id);
    if (mq[k].size() > mpk[k]) mpk[k] = mq[k].size();
  endtask

  always @(negedge clk)
    mon(0, 16, 14, 2, rst_a, a_out.valid, a_out.ready,
        a_out.data, a_in.valid, a_in.ready, a_in.data,
        fl_a, int'(cnt_a), int'(pk_a), af_a, ae_a);

  always @(negedge clk)
    mon(1, 5, 3, 2, rst_b, b_out.valid, b_out.ready,
        b_out.data, b_in.valid, b_in.ready, b_in.data,
        fl_b, int'(cnt_b), int'(pk_b), af_b, ae_b);

  task automatic sa(bit iv, logic [7:0] d, bit ordy, bit fl);
    a_in.valid = iv;
    a_in.data = d;
    a_out.ready = ordy;
    fl_a = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic sb(bit iv, logic [7:0] d, bit ordy, bit fl);
    b_in.valid = iv;
    b_in.data = d;
    b_out.ready = ordy;
    fl_b = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    fl_a = 1'b0;
    fl_b = 1'b0;
    a_in.valid = 1'b0;
    a_in.data = '0;
    a_out.ready = 1'b0;
    b_in.valid = 1'b0;
    b_in.data = '0;
    b_out.ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 0, int'(a_in.ready), 1);

    // fill
    for (int i = 0; i < 16; i++) sa(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_count", 0, int'(cnt_a), 16);
    chk("fill_ready", 0, int'(a_in.ready), 0);
    chk("fill_peak", 0, int'(pk_a), 16);
    sa(1'b1, 8'hEE, 1'b0, 1'b0);

    // drain
    for (int i = 0; i < 16; i++) sa(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_count", 0, int'(cnt_a), 0);
    chk("drain_valid", 0, int'(a_out.valid), 0);

    // streaming at steady occupancy
    sa(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) sa(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 8; i < 108; i++) sa(1'b1, 8'(i), 1'b1, 1'b0);
    chk("stream_count", 0, int'(cnt_a), 8);
    chk("stream_peak", 0, int'(pk_a), 8);
    for (int i = 0; i < 8; i++) sa(1'b0, 8'h00, 1'b1, 1'b0);

    // empty latency
    sa(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("lat_valid", 0, int'(a_out.valid), 1);
    chk("lat_data", 0, int'(a_out.data), 8'hA5);
    sa(1'b0, 8'h00, 1'b1, 1'b0);
    chk("lat_count", 0, int'(cnt_a), 0);

    // flush with a word on offer
    for (int i = 0; i < 5; i++) sa(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    a_in.valid = 1'b1;
    a_in.data = 8'h77;
    fl_a = 1'b1;
    #1;
    chk("flush_ready", 0, int'(a_in.ready), 0);
    @(posedge clk);
    #1;
    chk("flush_count", 0, int'(cnt_a), 0);
    chk("flush_valid", 0, int'(a_out.valid), 0);
    chk("flush_peak", 0, int'(pk_a), 0);
    for (int i = 0; i < 3; i++) sa(1'b0, 8'h00, 1'b1, 1'b0);

    // random traffic with occasional flush
    for (int i = 0; i < 400; i++)
      sa(1'($urandom_range(0, 1)), 8'($urandom),
         1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
    sa(1'b0, 8'h00, 1'b0, 1'b0);

    // DEPTH=5 fill/drain rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) sb(1'b1, 8'($urandom), 1'b0, 1'b0);
      chk("b_full_count", 1, int'(cnt_b), 5);
      chk("b_full_ready", 1, int'(b_in.ready), 0);
      for (int i = 0; i < 3; i++) sb(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) sb(1'b1, 8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) sb(1'b0, 8'h00, 1'b1, 1'b0);
      chk("b_drain_count", 1, int'(cnt_b), 0);
    end
    for (int i = 0; i < 200; i++)
      sb(1'($urandom_range(0, 1)), 8'($urandom),
         1'($urandom_range(0, 1)), 1'b0);

    // async reset mid-stream
    for (int i = 0; i < 3; i++) sb(1'b1, 8'($urandom), 1'b0, 1'b0);
    b_in.valid = 1'b1;
    b_out.ready = 1'b1;
    #2;
    rst_b = 1'b0;
    #1;
    chk("b_rst_count", 1, int'(cnt_b), 0);
    chk("b_rst_valid", 1, int'(b_out.valid), 0);
    @(posedge clk);
    #2;
    rst_b = 1'b1;
    for (int i = 0; i < 100; i++)
      sb(1'($urandom_range(0, 1)), 8'($urandom),
         1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
    sb(1'b0, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
